// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR random-number block: tap table, FSM encoding, lockup constant.
// Pure constants and functions; no timing or flow-control behaviour of its own.
package lfsr_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    function automatic logic [31:0] tap_bit(input int b);
        return 32'd1 << (b - 1);
    endfunction

    // Maximal-length XNOR taps, 1-based bit numbers; every entry has an even tap count.
    function automatic logic [31:0] lfsr_taps(input int n);
        case (n)
            3:  return tap_bit(3)  | tap_bit(2);
            4:  return tap_bit(4)  | tap_bit(3);
            5:  return tap_bit(5)  | tap_bit(3);
            6:  return tap_bit(6)  | tap_bit(5);
            7:  return tap_bit(7)  | tap_bit(6);
            8:  return tap_bit(8)  | tap_bit(6)  | tap_bit(5)  | tap_bit(4);
            9:  return tap_bit(9)  | tap_bit(5);
            10: return tap_bit(10) | tap_bit(7);
            11: return tap_bit(11) | tap_bit(9);
            12: return tap_bit(12) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
            13: return tap_bit(13) | tap_bit(4)  | tap_bit(3)  | tap_bit(1);
            14: return tap_bit(14) | tap_bit(5)  | tap_bit(3)  | tap_bit(1);
            15: return tap_bit(15) | tap_bit(14);
            16: return tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
            17: return tap_bit(17) | tap_bit(14);
            18: return tap_bit(18) | tap_bit(11);
            19: return tap_bit(19) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
            20: return tap_bit(20) | tap_bit(17);
            21: return tap_bit(21) | tap_bit(19);
            22: return tap_bit(22) | tap_bit(21);
            23: return tap_bit(23) | tap_bit(18);
            24: return tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
            25: return tap_bit(25) | tap_bit(22);
            26: return tap_bit(26) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
            27: return tap_bit(27) | tap_bit(5)  | tap_bit(2)  | tap_bit(1);
            28: return tap_bit(28) | tap_bit(25);
            29: return tap_bit(29) | tap_bit(27);
            30: return tap_bit(30) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
            31: return tap_bit(31) | tap_bit(28);
            32: return tap_bit(32) | tap_bit(22) | tap_bit(2)  | tap_bit(1);
            default: return 32'd0;
        endcase
    endfunction

    // All-ones is the state an XNOR LFSR can never leave.
    function automatic logic [31:0] lockup_value(input int n);
        return 32'hFFFF_FFFF >> (32 - n);
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci XNOR LFSR with seed load; a lockup seed is replaced by all-zeros.
// One step per cycle when step is high, seed_load has priority; no backpressure.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int NUM_BITS = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step,
    input  logic                seed_load,
    input  logic [NUM_BITS-1:0] seed,
    output logic [NUM_BITS-1:0] state
);

    localparam logic [31:0]         TAPS_FULL   = lfsr_taps(NUM_BITS);
    localparam logic [31:0]         LOCKUP_FULL = lockup_value(NUM_BITS);
    localparam logic [NUM_BITS-1:0] TAP_MASK    = TAPS_FULL[NUM_BITS-1:0];
    localparam logic [NUM_BITS-1:0] LOCKUP      = LOCKUP_FULL[NUM_BITS-1:0];

    logic feedback;

    // Even tap count, so chained XNOR reduces to inverted parity of the tapped bits.
    assign feedback = ~^(state & TAP_MASK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= '0;
        end else if (seed_load) begin
            state <= (seed == LOCKUP) ? '0 : seed;
        end else if (step) begin
            state <= {state[NUM_BITS-2:0], feedback};
        end
    end

endmodule

// File: rtl/lfsr_rng.sv
// Free-running LFSR plus rejection-sampled ranged output [0, i_Range).
// Request to o_Valid in 2..MAX_TRIES+1 cycles; requests outside IDLE are dropped.
module lfsr_rng
    import lfsr_pkg::*;
#(
    parameter int NUM_BITS  = 10,
    parameter int OUT_BITS  = 8,
    parameter int MAX_TRIES = 4
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic                i_Enable,
    input  logic                i_Seed_Load,
    input  logic [NUM_BITS-1:0] i_Seed,
    input  logic                i_Req,
    input  logic [OUT_BITS-1:0] i_Range,
    output logic [NUM_BITS-1:0] o_LFSR_Data,
    output logic                o_Busy,
    output logic                o_Valid,
    output logic [OUT_BITS-1:0] o_Value
);

    localparam logic [3:0] TRY_LAST = 4'(MAX_TRIES - 1);

    logic [1:0]          state_q;
    logic [OUT_BITS-1:0] range_q;
    logic [OUT_BITS-1:0] mask_q;
    logic [OUT_BITS-1:0] value_q;
    logic [3:0]          tries_q;
    logic                valid_q;
    logic [NUM_BITS-1:0] lfsr_state;
    logic [OUT_BITS-1:0] cand;
    logic [OUT_BITS-1:0] range_m1;
    logic [OUT_BITS-1:0] mask_next;
    logic                core_step;

    assign core_step = (state_q == ST_SAMPLE) | i_Enable;

    lfsr_core #(
        .NUM_BITS (NUM_BITS)
    ) u_core (
        .clk       (i_Clk),
        .rst       (i_Rst),
        .step      (core_step),
        .seed_load (i_Seed_Load),
        .seed      (i_Seed),
        .state     (lfsr_state)
    );

    assign cand     = lfsr_state[OUT_BITS-1:0] & mask_q;
    assign range_m1 = i_Range - OUT_BITS'(1);

    // Smallest 2^k-1 covering range-1: set every bit at or below the top set bit.
    always_comb begin
        mask_next = '0;
        for (int i = 0; i < OUT_BITS; i++) begin
            mask_next[i] = ((range_m1 >> i) != '0);
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= ST_IDLE;
            range_q <= '0;
            mask_q  <= '0;
            tries_q <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_Req) begin
                        range_q <= i_Range;
                        mask_q  <= mask_next;
                        tries_q <= '0;
                        state_q <= (i_Range <= OUT_BITS'(1)) ? ST_DONE : ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (cand < range_q) begin
                        value_q <= cand;
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (tries_q == TRY_LAST) begin
                        value_q <= cand - range_q;
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        tries_q <= tries_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    // Trivial ranges arrive here with nothing captured; their zero result pulses on exit.
                    if (!valid_q) begin
                        value_q <= '0;
                        valid_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_LFSR_Data = lfsr_state;
    assign o_Busy      = (state_q == ST_SAMPLE);
    assign o_Valid     = valid_q;
    assign o_Value     = value_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// Bench for lfsr_rng (N=10, OUT=8, MAX_TRIES=4): vector table, corner sequences, randomized requests.
module tb_lfsr_rng;

    localparam int MAX_TRIES = 4;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       seed_load;
    logic [9:0] seed;
    logic       req;
    logic [7:0] range_in;
    logic [9:0] lfsr_data;
    logic       busy;
    logic       valid;
    logic [7:0] value;

    int n_pass;
    int n_total;
    int unsigned model_lfsr;
    int hist[5];

    typedef struct {
        logic       load;
        logic [9:0] seed;
        logic       en;
        logic [9:0] exp_lfsr;
    } vec_t;

    vec_t vecs[11];

    lfsr_rng #(
        .NUM_BITS  (10),
        .OUT_BITS  (8),
        .MAX_TRIES (MAX_TRIES)
    ) dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_Enable    (enable),
        .i_Seed_Load (seed_load),
        .i_Seed      (seed),
        .i_Req       (req),
        .i_Range     (range_in),
        .o_LFSR_Data (lfsr_data),
        .o_Busy      (busy),
        .o_Valid     (valid),
        .o_Value     (value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // x^10 + x^7 + 1 in XNOR form: shift left, new LSB = 1 - (bit9 xor bit6).
    function automatic int unsigned lfsr_next(input int unsigned s);
        int unsigned fb;
        fb = 1 - (((s / 512) % 2) ^ ((s / 64) % 2));
        return ((s * 2) % 1024) + fb;
    endfunction

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_lfsr = 0;
    endtask

    task automatic idle_gap();
        int n;
        n = $urandom_range(0, 4);
        for (int i = 0; i < n; i++) begin
            enable    = 1'($urandom_range(0, 1));
            seed_load = ($urandom_range(0, 7) == 0);
            seed      = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0) seed = 10'h3FF;
            if (seed_load) model_lfsr = (seed == 10'h3FF) ? 0 : 32'(seed);
            else if (enable) model_lfsr = lfsr_next(model_lfsr);
            tick();
        end
        enable    = 1'b0;
        seed_load = 1'b0;
        chk("gap_lfsr", 32'(lfsr_data), model_lfsr);
    endtask

    task automatic do_request(input int unsigned r);
        int unsigned s, m, cand, exp_val, exp_lat, lat;
        bit busy_seen, got;
        s = model_lfsr;
        exp_val = 0;
        exp_lat = 2;
        if (r >= 2) begin
            m = 0;
            while (m < r - 1) m = m * 2 + 1;
            for (int t = 0; t < MAX_TRIES; t++) begin
                cand = (s % 256) & m;
                s = lfsr_next(s);
                if (cand < r) begin
                    exp_val = cand;
                    exp_lat = t + 2;
                    break;
                end
                if (t == MAX_TRIES - 1) begin
                    exp_val = cand - r;
                    exp_lat = MAX_TRIES + 1;
                end
            end
        end
        model_lfsr = s;
        req = 1'b1;
        range_in = r[7:0];
        lat = 0;
        busy_seen = 1'b0;
        got = 1'b0;
        while (!got && lat < 20) begin
            tick();
            lat++;
            req = 1'b0;
            if (busy) busy_seen = 1'b1;
            if (valid) got = 1'b1;
        end
        chk("req_latency", got ? lat : 99, exp_lat);
        chk("req_value", 32'(value), exp_val);
        chk("req_lfsr", 32'(lfsr_data), model_lfsr);
        chk("req_busy_seen", 32'(busy_seen), (r >= 2) ? 1 : 0);
        if (r >= 2) chk("req_in_range", 32'(value < r[7:0]), 1);
        if (r == 5 && value < 5) hist[value]++;
        tick();
    endtask

    initial begin
        int lat, extra, repeats;
        bit seen[1024];

        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        enable = 1'b0;
        seed_load = 1'b0;
        seed = '0;
        req = 1'b0;
        range_in = '0;
        model_lfsr = 0;
        for (int i = 0; i < 5; i++) hist[i] = 0;

        vecs[0]  = '{1'b0, 10'h000, 1'b1, 10'h001};
        vecs[1]  = '{1'b0, 10'h000, 1'b1, 10'h003};
        vecs[2]  = '{1'b0, 10'h000, 1'b1, 10'h007};
        vecs[3]  = '{1'b1, 10'h3FF, 1'b0, 10'h000};
        vecs[4]  = '{1'b1, 10'h155, 1'b0, 10'h155};
        vecs[5]  = '{1'b0, 10'h000, 1'b1, 10'h2AA};
        vecs[6]  = '{1'b0, 10'h000, 1'b1, 10'h154};
        vecs[7]  = '{1'b1, 10'h0F0, 1'b1, 10'h0F0};
        vecs[8]  = '{1'b0, 10'h000, 1'b0, 10'h0F0};
        vecs[9]  = '{1'b1, 10'h3FE, 1'b0, 10'h3FE};
        vecs[10] = '{1'b0, 10'h000, 1'b1, 10'h3FD};

        tick();
        tick();
        chk("rst_lfsr", 32'(lfsr_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_value", 32'(value), 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            seed_load = vecs[i].load;
            seed      = vecs[i].seed;
            enable    = vecs[i].en;
            tick();
            chk($sformatf("vec%0d_lfsr", i), 32'(lfsr_data), 32'(vecs[i].exp_lfsr));
        end
        seed_load = 1'b0;
        enable = 1'b0;

        // Full period from zero: 1023 distinct states, then back to zero.
        reset_pulse();
        for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
        seen[0] = 1'b1;
        repeats = 0;
        enable = 1'b1;
        for (int i = 1; i < 1023; i++) begin
            tick();
            model_lfsr = lfsr_next(model_lfsr);
            if (seen[lfsr_data]) repeats++;
            seen[lfsr_data] = 1'b1;
            chk("period_step", 32'(lfsr_data), model_lfsr);
        end
        tick();
        enable = 1'b0;
        chk("period_repeats", repeats, 0);
        chk("period_wrap", 32'(lfsr_data), 0);
        model_lfsr = 0;

        // Every try rejected: fallback on the last try; held i_Req and a changed i_Range are ignored.
        seed_load = 1'b1;
        seed = 10'h003;
        tick();
        seed_load = 1'b0;
        req = 1'b1;
        range_in = 8'd3;
        tick();
        lat = 1;
        range_in = 8'd200;
        while (!valid && lat < 20) begin
            tick();
            lat++;
        end
        req = 1'b0;
        chk("fallback_latency", lat, MAX_TRIES + 1);
        chk("fallback_value", 32'(value), 0);
        chk("fallback_lfsr", 32'(lfsr_data), 32'h03F);
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (valid) extra++;
        end
        chk("ignored_req_pulses", extra, 0);

        // Seed load in the first SAMPLE cycle redirects the remaining tries.
        seed_load = 1'b1;
        seed = 10'h003;
        tick();
        seed_load = 1'b0;
        req = 1'b1;
        range_in = 8'd3;
        tick();
        req = 1'b0;
        seed_load = 1'b1;
        seed = 10'h0FF;
        tick();
        seed_load = 1'b0;
        lat = 2;
        while (!valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("midload_latency", lat, 4);
        chk("midload_value", 32'(value), 2);
        chk("midload_lfsr", 32'(lfsr_data), 32'h3FC);
        tick();

        // Reset while sampling aborts the request.
        req = 1'b1;
        range_in = 8'd200;
        tick();
        req = 1'b0;
        chk("abort_busy_before", 32'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_lfsr", 32'(lfsr_data), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(valid), 0);
        chk("abort_value", 32'(value), 0);
        tick();
        tick();
        rst = 1'b0;
        model_lfsr = 0;
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (valid) extra++;
        end
        chk("abort_pulses", extra, 0);
        do_request(5);

        do_request(1);
        do_request(0);
        do_request(2);
        do_request(255);

        for (int i = 0; i < 1000; i++) begin
            idle_gap();
            do_request(5);
        end
        for (int k = 0; k < 5; k++) chk($sformatf("hist_%0d_seen", k), 32'(hist[k] > 0), 1);

        for (int i = 0; i < 300; i++) begin
            idle_gap();
            do_request($urandom_range(0, 255));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
